alu_rs: RTL and testbench

- Reservation station on the issue side of the ALU in the out-of-order core.
- Accepts dispatched integer ops whose operands may still be pending ROB tags.
- Snoops two CDB broadcast ports to wake up pending operands.
- Issues one fully ready entry per cycle to the ALU as a registered op/operand/destination bundle.

---
 rtl/alu_rs_if.sv | 48 ++++
 rtl/alu_rs.sv | 204 ++++++++++++++++++++
 tb/tb_alu_rs.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Issue-side bundle for the ALU reservation station: control, dispatch, two CDB snoop ports and the ALU issue bus.
// The master drives dispatch and CDB traffic; the slave (alu_rs) drives full_out and the alu_* issue registers.
interface alu_rs_if #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 5
);
  logic             rdy_in;
  logic             flush_in;
  logic             disp_valid_in;
  logic [OP_W-1:0]  disp_op_in;
  logic [31:0]      disp_vj_in;
  logic             disp_qj_busy_in;
  logic [TAG_W-1:0] disp_qj_in;
  logic [31:0]      disp_vk_in;
  logic             disp_qk_busy_in;
  logic [TAG_W-1:0] disp_qk_in;
  logic [TAG_W-1:0] disp_dest_in;
  logic             full_out;
  logic             cdb0_valid_in;
  logic [TAG_W-1:0] cdb0_tag_in;
  logic [31:0]      cdb0_val_in;
  logic             cdb1_valid_in;
  logic [TAG_W-1:0] cdb1_tag_in;
  logic [31:0]      cdb1_val_in;
  logic             alu_valid_out;
  logic [OP_W-1:0]  alu_op_out;
  logic [31:0]      alu_a_out;
  logic [31:0]      alu_b_out;
  logic [TAG_W-1:0] alu_dest_out;

  modport master (
    output rdy_in, flush_in,
    output disp_valid_in, disp_op_in, disp_vj_in, disp_qj_busy_in, disp_qj_in,
    output disp_vk_in, disp_qk_busy_in, disp_qk_in, disp_dest_in,
    output cdb0_valid_in, cdb0_tag_in, cdb0_val_in,
    output cdb1_valid_in, cdb1_tag_in, cdb1_val_in,
    input  full_out, alu_valid_out, alu_op_out, alu_a_out, alu_b_out, alu_dest_out
  );

  modport slave (
    input  rdy_in, flush_in,
    input  disp_valid_in, disp_op_in, disp_vj_in, disp_qj_busy_in, disp_qj_in,
    input  disp_vk_in, disp_qk_busy_in, disp_qk_in, disp_dest_in,
    input  cdb0_valid_in, cdb0_tag_in, cdb0_val_in,
    input  cdb1_valid_in, cdb1_tag_in, cdb1_val_in,
    output full_out, alu_valid_out, alu_op_out, alu_a_out, alu_b_out, alu_dest_out
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: CDB-snooping wakeup, one registered issue per cycle; define ALU_RS_AGE_EN for oldest-first issue.
// Dispatch-to-issue is 2 edges minimum; the ALU never stalls, and dispatch is dropped while full_out is high.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 5
) (
  input logic     clk_in,
  input logic     rst_in,
  alu_rs_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qj_busy;
  logic [RS_SIZE-1:0] r_qk_busy;
  logic [OP_W-1:0]    r_op   [RS_SIZE];
  logic [31:0]        r_vj   [RS_SIZE];
  logic [31:0]        r_vk   [RS_SIZE];
  logic [TAG_W-1:0]   r_qj   [RS_SIZE];
  logic [TAG_W-1:0]   r_qk   [RS_SIZE];
  logic [TAG_W-1:0]   r_dest [RS_SIZE];

  logic               r_full;
  logic               r_alu_valid;
  logic [OP_W-1:0]    r_alu_op;
  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [TAG_W-1:0]   r_alu_dest;

  logic [RS_SIZE-1:0] w_eligible;
  logic [RS_SIZE-1:0] w_iss_oh;
  logic [RS_SIZE-1:0] w_disp_oh;
  logic [RS_SIZE-1:0] w_busy_nxt;
  logic               w_iss_vld;
  logic [IDX_W-1:0]   w_iss_idx;
  logic               w_free_vld;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_disp_fire;
  logic [32:0]        w_j_snp [RS_SIZE];
  logic [32:0]        w_k_snp [RS_SIZE];
  logic [32:0]        w_dj_snp;
  logic [32:0]        w_dk_snp;

  // {hit, value}; port 0 takes precedence when both ports carry the same tag
  function automatic logic [32:0] snoop(input logic [TAG_W-1:0] tag);
    logic [32:0] res;
    res = '0;
    if (bus.cdb0_valid_in && bus.cdb0_tag_in == tag)
      res = {1'b1, bus.cdb0_val_in};
    else if (bus.cdb1_valid_in && bus.cdb1_tag_in == tag)
      res = {1'b1, bus.cdb1_val_in};
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_j_snp[i] = snoop(r_qj[i]);
      w_k_snp[i] = snoop(r_qk[i]);
    end
    w_dj_snp = snoop(bus.disp_qj_in);
    w_dk_snp = snoop(bus.disp_qk_in);
  end

  assign w_eligible = r_busy & ~r_qj_busy & ~r_qk_busy;

`ifdef ALU_RS_AGE_EN
  logic [IDX_W-1:0] r_age [RS_SIZE];
  logic [IDX_W-1:0] w_best_age;

  // strict '>' keeps the lowest index among equally old entries
  always_comb begin
    w_iss_vld  = 1'b0;
    w_iss_idx  = '0;
    w_best_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_eligible[i] && (!w_iss_vld || r_age[i] > w_best_age)) begin
        w_iss_vld  = 1'b1;
        w_iss_idx  = IDX_W'(i);
        w_best_age = r_age[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
    end else if (bus.rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_disp_oh[i])
          r_age[i] <= '0;
        else if (r_busy[i] && r_age[i] != '1)
          r_age[i] <= r_age[i] + IDX_W'(1);
      end
    end
  end
`else
  always_comb begin
    w_iss_vld = 1'b0;
    w_iss_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_iss_vld = 1'b1;
        w_iss_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_vld = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
    // free slots are judged from registered state, so a same-cycle issue does not open room
    w_disp_fire = bus.disp_valid_in && !r_full && w_free_vld;
    w_disp_oh   = '0;
    if (w_disp_fire) w_disp_oh[w_free_idx] = 1'b1;
    w_iss_oh    = '0;
    if (w_iss_vld) w_iss_oh[w_iss_idx] = 1'b1;
    w_busy_nxt  = (r_busy & ~w_iss_oh) | w_disp_oh;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy      <= '0;
      r_qj_busy   <= '0;
      r_qk_busy   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]   <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_dest[i] <= '0;
      end
      r_full      <= 1'b0;
      r_alu_valid <= 1'b0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_dest  <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        r_busy      <= '0;
        r_full      <= 1'b0;
        r_alu_valid <= 1'b0;
      end else begin
        r_busy      <= w_busy_nxt;
        r_full      <= &w_busy_nxt;
        r_alu_valid <= w_iss_vld;
        if (w_iss_vld) begin
          r_alu_op   <= r_op[w_iss_idx];
          r_alu_a    <= r_vj[w_iss_idx];
          r_alu_b    <= r_vk[w_iss_idx];
          r_alu_dest <= r_dest[w_iss_idx];
        end
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && !w_iss_oh[i]) begin
            if (r_qj_busy[i] && w_j_snp[i][32]) begin
              r_vj[i]      <= w_j_snp[i][31:0];
              r_qj_busy[i] <= 1'b0;
            end
            if (r_qk_busy[i] && w_k_snp[i][32]) begin
              r_vk[i]      <= w_k_snp[i][31:0];
              r_qk_busy[i] <= 1'b0;
            end
          end
        end
        if (w_disp_fire) begin
          r_op[w_free_idx]   <= bus.disp_op_in;
          r_dest[w_free_idx] <= bus.disp_dest_in;
          r_qj[w_free_idx]   <= bus.disp_qj_in;
          r_qk[w_free_idx]   <= bus.disp_qk_in;
          if (bus.disp_qj_busy_in && w_dj_snp[32]) begin
            r_vj[w_free_idx]      <= w_dj_snp[31:0];
            r_qj_busy[w_free_idx] <= 1'b0;
          end else begin
            r_vj[w_free_idx]      <= bus.disp_vj_in;
            r_qj_busy[w_free_idx] <= bus.disp_qj_busy_in;
          end
          if (bus.disp_qk_busy_in && w_dk_snp[32]) begin
            r_vk[w_free_idx]      <= w_dk_snp[31:0];
            r_qk_busy[w_free_idx] <= 1'b0;
          end else begin
            r_vk[w_free_idx]      <= bus.disp_vk_in;
            r_qk_busy[w_free_idx] <= bus.disp_qk_busy_in;
          end
        end
      end
    end
  end

  assign bus.full_out      = r_full;
  assign bus.alu_valid_out = r_alu_valid;
  assign bus.alu_op_out    = r_alu_op;
  assign bus.alu_a_out     = r_alu_a;
  assign bus.alu_b_out     = r_alu_b;
  assign bus.alu_dest_out  = r_alu_dest;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue latency, CDB wakeup/forwarding, full handling, flush, rdy freeze and async reset.
module tb_alu_rs;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_rs_if #(.TAG_W(4), .OP_W(5)) bus ();
  alu_rs #(.RS_SIZE(8), .TAG_W(4), .OP_W(5)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.rdy_in = 1'b1;          bus.flush_in = 1'b0;
    bus.disp_valid_in = 1'b0;   bus.disp_op_in = '0;
    bus.disp_vj_in = '0;        bus.disp_qj_busy_in = 1'b0;  bus.disp_qj_in = '0;
    bus.disp_vk_in = '0;        bus.disp_qk_busy_in = 1'b0;  bus.disp_qk_in = '0;
    bus.disp_dest_in = '0;
    bus.cdb0_valid_in = 1'b0;   bus.cdb0_tag_in = '0;  bus.cdb0_val_in = '0;
    bus.cdb1_valid_in = 1'b0;   bus.cdb1_tag_in = '0;  bus.cdb1_val_in = '0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                      input logic [31:0] vk, input logic qkb, input logic [3:0] qk, input logic [3:0] dest);
    bus.disp_valid_in = 1'b1;  bus.disp_op_in = op;
    bus.disp_vj_in = vj;  bus.disp_qj_busy_in = qjb;  bus.disp_qj_in = qj;
    bus.disp_vk_in = vk;  bus.disp_qk_busy_in = qkb;  bus.disp_qk_in = qk;
    bus.disp_dest_in = dest;
  endtask

  task automatic test_reset();
    idle();
    tick();
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", bus.alu_valid_out); end
    checks++; if (bus.full_out !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h expected 0", bus.full_out); end
    checks++; if (bus.alu_op_out !== 5'd0) begin errors++; $display("FAIL reset_op: got %0h expected 0", bus.alu_op_out); end
    checks++; if (bus.alu_a_out !== 32'd0 || bus.alu_b_out !== 32'd0) begin errors++; $display("FAIL reset_ab: got %0h/%0h expected 0/0", bus.alu_a_out, bus.alu_b_out); end
    checks++; if (bus.alu_dest_out !== 4'd0) begin errors++; $display("FAIL reset_dest: got %0h expected 0", bus.alu_dest_out); end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_ready_issue();
    disp(5'd3, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd6);
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL ready_edge1_valid: got %0h expected 0", bus.alu_valid_out); end
    checks++; if (bus.full_out !== 1'b0) begin errors++; $display("FAIL ready_edge1_full: got %0h expected 0", bus.full_out); end
    idle();
    tick();
    checks++; if (bus.alu_valid_out !== 1'b1) begin errors++; $display("FAIL ready_edge2_valid: got %0h expected 1", bus.alu_valid_out); end
    checks++; if (bus.alu_op_out !== 5'd3 || bus.alu_dest_out !== 4'd6) begin errors++; $display("FAIL ready_op_dest: got %0h/%0h expected 3/6", bus.alu_op_out, bus.alu_dest_out); end
    checks++; if (bus.alu_a_out !== 32'd5 || bus.alu_b_out !== 32'd7) begin errors++; $display("FAIL ready_ab: got %0h/%0h expected 5/7", bus.alu_a_out, bus.alu_b_out); end
    checks++; if (bus.full_out !== 1'b0) begin errors++; $display("FAIL ready_edge2_full: got %0h expected 0", bus.full_out); end
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL ready_strobe_drop: got %0h expected 0", bus.alu_valid_out); end
    checks++; if (bus.alu_a_out !== 32'd5) begin errors++; $display("FAIL ready_hold_a: got %0h expected 5", bus.alu_a_out); end
  endtask

  task automatic test_wakeup();
    disp(5'd1, 32'd0, 1'b1, 4'd4, 32'd3, 1'b0, 4'd0, 4'd2);
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL wake_pending: got %0h expected 0", bus.alu_valid_out); end
    idle();
    bus.cdb1_valid_in = 1'b1; bus.cdb1_tag_in = 4'd4; bus.cdb1_val_in = 32'hDEADBEEF;
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL wake_capture_edge: got %0h expected 0", bus.alu_valid_out); end
    idle();
    tick();
    checks++; if (bus.alu_valid_out !== 1'b1) begin errors++; $display("FAIL wake_issue_valid: got %0h expected 1", bus.alu_valid_out); end
    checks++; if (bus.alu_a_out !== 32'hDEADBEEF || bus.alu_b_out !== 32'd3) begin errors++; $display("FAIL wake_ab: got %0h/%0h expected deadbeef/3", bus.alu_a_out, bus.alu_b_out); end
    checks++; if (bus.alu_dest_out !== 4'd2) begin errors++; $display("FAIL wake_dest: got %0h expected 2", bus.alu_dest_out); end
  endtask

  task automatic test_dual_cdb_forward();
    disp(5'd2, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 4'd9);
    bus.cdb0_valid_in = 1'b1; bus.cdb0_tag_in = 4'd9; bus.cdb0_val_in = 32'h11;
    bus.cdb1_valid_in = 1'b1; bus.cdb1_tag_in = 4'd9; bus.cdb1_val_in = 32'h22;
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL fwd_edge1_valid: got %0h expected 0", bus.alu_valid_out); end
    idle();
    tick();
    checks++; if (bus.alu_valid_out !== 1'b1) begin errors++; $display("FAIL fwd_issue_valid: got %0h expected 1", bus.alu_valid_out); end
    checks++; if (bus.alu_b_out !== 32'h11 || bus.alu_a_out !== 32'd1) begin errors++; $display("FAIL fwd_port0_wins: got a=%0h b=%0h expected a=1 b=11", bus.alu_a_out, bus.alu_b_out); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      disp(5'(i + 1), 32'd0, 1'b1, 4'd2, 32'(100 + i), 1'b0, 4'd0, 4'(i));
      tick();
      checks++; if (bus.full_out !== (i == 7)) begin errors++; $display("FAIL full_fill%0d: got %0h expected %0h", i, bus.full_out, (i == 7)); end
    end
    disp(5'd31, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0, 4'd15);
    tick();
    checks++; if (bus.full_out !== 1'b1 || bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL full_drop9: got full=%0h valid=%0h expected 1/0", bus.full_out, bus.alu_valid_out); end
    idle();
    bus.cdb0_valid_in = 1'b1; bus.cdb0_tag_in = 4'd2; bus.cdb0_val_in = 32'hAB;
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0 || bus.full_out !== 1'b1) begin errors++; $display("FAIL full_bcast_edge: got valid=%0h full=%0h expected 0/1", bus.alu_valid_out, bus.full_out); end
    idle();
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++;
      if (bus.alu_valid_out !== 1'b1 || bus.alu_dest_out !== 4'(j) || bus.alu_op_out !== 5'(j + 1) ||
          bus.alu_a_out !== 32'hAB || bus.alu_b_out !== 32'(100 + j)) begin
        errors++;
        $display("FAIL full_issue%0d: got v=%0h dest=%0h op=%0h a=%0h b=%0h expected v=1 dest=%0h op=%0h a=ab b=%0h",
                 j, bus.alu_valid_out, bus.alu_dest_out, bus.alu_op_out, bus.alu_a_out, bus.alu_b_out, j, j + 1, 100 + j);
      end
      checks++; if (bus.full_out !== 1'b0) begin errors++; $display("FAIL full_clear%0d: got %0h expected 0", j, bus.full_out); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL full_no_ninth%0d: got %0h expected 0", k, bus.alu_valid_out); end
    end
  endtask

  task automatic test_flush();
    disp(5'd7, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 4'd10);
    tick();
    disp(5'd8, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 4'd11);
    tick();
    disp(5'd9, 32'd4, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 4'd12);
    tick();
    disp(5'd10, 32'd6, 1'b0, 4'd0, 32'd6, 1'b0, 4'd0, 4'd13);
    bus.flush_in = 1'b1;
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0h expected 0", bus.alu_valid_out); end
    checks++; if (bus.full_out !== 1'b0) begin errors++; $display("FAIL flush_full: got %0h expected 0", bus.full_out); end
    idle();
    bus.cdb0_valid_in = 1'b1; bus.cdb0_tag_in = 4'd5; bus.cdb0_val_in = 32'd1;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL flush_no_issue%0d: got %0h expected 0", k, bus.alu_valid_out); end
    end
  endtask

  task automatic test_freeze_and_async_reset();
    disp(5'd4, 32'h55, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 4'd3);
    tick();
    disp(5'd5, 32'd0, 1'b1, 4'd6, 32'h77, 1'b0, 4'd0, 4'd7);
    tick();
    checks++; if (bus.alu_valid_out !== 1'b1 || bus.alu_a_out !== 32'h55) begin errors++; $display("FAIL frz_pre_issue: got v=%0h a=%0h expected 1/55", bus.alu_valid_out, bus.alu_a_out); end
    idle();
    bus.rdy_in = 1'b0;
    bus.cdb0_valid_in = 1'b1; bus.cdb0_tag_in = 4'd6; bus.cdb0_val_in = 32'h99;
    disp(5'd6, 32'h1, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 4'd14);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.alu_valid_out !== 1'b1 || bus.alu_a_out !== 32'h55 || bus.alu_dest_out !== 4'd3 || bus.full_out !== 1'b0) begin
        errors++;
        $display("FAIL frz_hold%0d: got v=%0h a=%0h dest=%0h full=%0h expected 1/55/3/0", k, bus.alu_valid_out, bus.alu_a_out, bus.alu_dest_out, bus.full_out);
      end
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL frz_no_wake%0d: got %0h expected 0", k, bus.alu_valid_out); end
    end
    bus.cdb1_valid_in = 1'b1; bus.cdb1_tag_in = 4'd6; bus.cdb1_val_in = 32'h99;
    tick();
    idle();
    tick();
    checks++; if (bus.alu_valid_out !== 1'b1 || bus.alu_a_out !== 32'h99 || bus.alu_dest_out !== 4'd7) begin errors++; $display("FAIL frz_late_issue: got v=%0h a=%0h dest=%0h expected 1/99/7", bus.alu_valid_out, bus.alu_a_out, bus.alu_dest_out); end
    #2;
    rst_in = 1'b0;
    #1;
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0h expected 0", bus.alu_valid_out); end
    checks++; if (bus.alu_a_out !== 32'd0 || bus.alu_dest_out !== 4'd0) begin errors++; $display("FAIL arst_data: got a=%0h dest=%0h expected 0/0", bus.alu_a_out, bus.alu_dest_out); end
    tick();
    rst_in = 1'b1;
    tick();
    tick();
    checks++; if (bus.alu_valid_out !== 1'b0) begin errors++; $display("FAIL arst_no_issue: got %0h expected 0", bus.alu_valid_out); end
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_dual_cdb_forward();
    test_full();
    test_flush();
    test_freeze_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
